// File: rtl/if_pc_ctrl.sv
// Instruction-fetch PC controller: one outstanding fetch, branch redirect with
// flush, and a registered misaligned-target exception pulse.
module if_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_control,
    input  logic [3:0]  branch_type,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        flush,
    output logic        misalign_exc
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] if_pc_reg;
    logic [31:0] if_inst_reg;
    logic        misalign_reg;
    logic        capture;

    logic        handshake;
    logic        redirect_req;
    logic        misaligned;
    logic        redirect;
    logic [31:0] eff_target;

    assign handshake = imem_req_valid & imem_req_ready;

    // Any of the low three qualifier bits redirects; auipc (bit 3) alone is
    // the only nonzero pattern that must not, hence the two exclusions.
    assign redirect_req = branch_control & (branch_type != 4'b0000) & (branch_type != 4'b1000);
    assign eff_target   = branch_type[1] ? {br_target[31:1], 1'b0} : br_target;
    assign misaligned   = redirect_req & (eff_target[1:0] != 2'b00);
    assign redirect     = redirect_req & ~misaligned;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        capture    = 1'b0;
        case (state_reg)
            ST_REQ:  if (handshake) state_next = ST_WAIT;
            ST_WAIT: if (imem_rsp_valid) begin
                state_next = ST_HOLD;
                capture    = 1'b1;
            end
            ST_HOLD: if (!stall) begin
                state_next = ST_REQ;
                pc_next    = pc_reg + 32'd4;
            end
            ST_DROP: if (imem_rsp_valid) state_next = ST_REQ;
            default: state_next = ST_REQ;
        endcase

        // A redirect wins over stall and the sequential increment; an
        // in-flight or same-cycle request must still have its response drained.
        if (redirect) begin
            pc_next = eff_target;
            capture = 1'b0;
            case (state_reg)
                ST_REQ:  state_next = handshake ? ST_DROP : ST_REQ;
                ST_WAIT: state_next = imem_rsp_valid ? ST_REQ : ST_DROP;
                ST_HOLD: state_next = ST_REQ;
                ST_DROP: state_next = imem_rsp_valid ? ST_REQ : ST_DROP;
                default: state_next = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_REQ;
            pc_reg       <= RESET_PC;
            if_pc_reg    <= 32'd0;
            if_inst_reg  <= 32'd0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            misalign_reg <= misaligned;
            if (capture) begin
                if_pc_reg   <= pc_reg;
                if_inst_reg <= imem_rsp_data;
            end
        end
    end

    assign imem_req_valid = rst_n & (state_reg == ST_REQ);
    assign imem_addr      = pc_reg;
    assign if_valid       = (state_reg == ST_HOLD);
    assign if_pc          = if_pc_reg;
    assign if_inst        = if_inst_reg;
    assign flush          = redirect;
    assign misalign_exc   = misalign_reg;

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Directed bench for if_pc_ctrl: the testbench plays the instruction memory by
// hand and checks each scenario against hand-computed values.
module tb_if_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_control;
    logic [3:0]  branch_type;
    logic [31:0] br_target;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        flush;
    logic        misalign_exc;

    int checks = 0;
    int errors = 0;

    if_pc_ctrl #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_control (branch_control),
        .branch_type    (branch_type),
        .br_target      (br_target),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .flush          (flush),
        .misalign_exc   (misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; branch_control = 1'b0; branch_type = 4'd0; br_target = 32'd0;
        stall = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%0h exp=0", imem_req_valid); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got=%0h exp=0", if_valid); end
        checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL reset_if_pc got=%08h exp=00000000", if_pc); end
        checks++; if (if_inst !== 32'd0) begin errors++; $display("FAIL reset_if_inst got=%08h exp=00000000", if_inst); end
        checks++; if (misalign_exc !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%0h exp=0", misalign_exc); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL post_reset_req_valid got=%0h exp=1", imem_req_valid); end
        checks++; if (imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL post_reset_addr got=%08h exp=80000000", imem_addr); end
        $display("reset: req_valid=%0h addr=%08h", imem_req_valid, imem_addr);
    endtask

    task automatic test_basic_fetch();
        imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_req_valid got=%0h exp=1", imem_req_valid); end
        step();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_req_valid got=%0h exp=0", imem_req_valid); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_if_valid got=%0h exp=0", if_valid); end
        step();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL basic_hold_if_valid got=%0h exp=1", if_valid); end
        checks++; if (if_pc !== 32'h8000_0000) begin errors++; $display("FAIL basic_if_pc got=%08h exp=80000000", if_pc); end
        checks++; if (if_inst !== 32'h0000_0013) begin errors++; $display("FAIL basic_if_inst got=%08h exp=00000013", if_inst); end
        step();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL basic_after_if_valid got=%0h exp=0", if_valid); end
        checks++; if (imem_addr !== 32'h8000_0004) begin errors++; $display("FAIL basic_next_addr got=%08h exp=80000004", imem_addr); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_next_req_valid got=%0h exp=1", imem_req_valid); end
        $display("basic_fetch: if_pc=80000000 inst=00000013 next_addr=%08h", imem_addr);
    endtask

    task automatic test_stall();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h1111_1111; stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) stall = 1'b0;
            #1;
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_if_valid[%0d] got=%0h exp=1", i, if_valid); end
            checks++; if (if_pc !== 32'h8000_0004) begin errors++; $display("FAIL stall_if_pc[%0d] got=%08h exp=80000004", i, if_pc); end
            checks++; if (if_inst !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_if_inst[%0d] got=%08h exp=deadbeef", i, if_inst); end
            step();
        end
        checks++; if (imem_addr !== 32'h8000_0008) begin errors++; $display("FAIL stall_next_addr got=%08h exp=80000008", imem_addr); end
        $display("stall: held 5 cycles, next_addr=%08h", imem_addr);
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        branch_control = 1'b1; branch_type = 4'b0100; br_target = 32'h8000_0100;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL redir_wait_flush got=%0h exp=1", flush); end
        step();
        branch_control = 1'b0; branch_type = 4'd0;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL redir_wait_flush_clear got=%0h exp=0", flush); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_drop_req_valid got=%0h exp=0", imem_req_valid); end
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0BAD;
        step();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_dropped_if_valid got=%0h exp=0", if_valid); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL redir_req_valid got=%0h exp=1", imem_req_valid); end
        checks++; if (imem_addr !== 32'h8000_0100) begin errors++; $display("FAIL redir_addr got=%08h exp=80000100", imem_addr); end
        $display("redirect_wait: next_addr=%08h if_valid=%0h", imem_addr, if_valid);
    endtask

    task automatic test_jalr_misalign();
        branch_control = 1'b1; branch_type = 4'b0010; br_target = 32'h8000_0201;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jalr_flush got=%0h exp=1", flush); end
        step();
        checks++; if (imem_addr !== 32'h8000_0200) begin errors++; $display("FAIL jalr_addr got=%08h exp=80000200", imem_addr); end
        checks++; if (misalign_exc !== 1'b0) begin errors++; $display("FAIL jalr_misalign got=%0h exp=0", misalign_exc); end
        br_target = 32'h8000_0202;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL misalign_flush got=%0h exp=0", flush); end
        step();
        branch_control = 1'b0; branch_type = 4'd0;
        #1;
        checks++; if (misalign_exc !== 1'b1) begin errors++; $display("FAIL misalign_pulse got=%0h exp=1", misalign_exc); end
        checks++; if (imem_addr !== 32'h8000_0200) begin errors++; $display("FAIL misalign_pc got=%08h exp=80000200", imem_addr); end
        step();
        checks++; if (misalign_exc !== 1'b0) begin errors++; $display("FAIL misalign_pulse_end got=%0h exp=0", misalign_exc); end
        $display("jalr_misalign: addr=%08h", imem_addr);
    endtask

    task automatic test_auipc_only();
        branch_control = 1'b1; branch_type = 4'b1000; br_target = 32'h8000_0400;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL auipc_flush got=%0h exp=0", flush); end
        step();
        branch_control = 1'b0; branch_type = 4'd0;
        checks++; if (imem_addr !== 32'h8000_0200) begin errors++; $display("FAIL auipc_pc got=%08h exp=80000200", imem_addr); end
        $display("auipc_only: addr=%08h", imem_addr);
    endtask

    task automatic test_wrap();
        branch_control = 1'b1; branch_type = 4'b0001; br_target = 32'hFFFF_FFFC;
        step();
        branch_control = 1'b0; branch_type = 4'd0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup_addr got=%08h exp=fffffffc", imem_addr); end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0001;
        step();
        imem_rsp_valid = 1'b0;
        checks++; if (if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_if_pc got=%08h exp=fffffffc", if_pc); end
        step();
        checks++; if (imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr got=%08h exp=00000000", imem_addr); end
        $display("wrap: next_addr=%08h", imem_addr);
    endtask

    task automatic test_back_to_back();
        // fetch at 0, redirect while stalled in HOLD
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0033;
        step();
        imem_rsp_valid = 1'b0; stall = 1'b1;
        branch_control = 1'b1; branch_type = 4'b0001; br_target = 32'h0000_1000;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL hold_redir_flush got=%0h exp=1", flush); end
        step();
        branch_control = 1'b0; branch_type = 4'd0; stall = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL hold_redir_if_valid got=%0h exp=0", if_valid); end
        checks++; if (imem_addr !== 32'h0000_1000) begin errors++; $display("FAIL hold_redir_addr got=%08h exp=00001000", imem_addr); end
        // redirect coinciding with the handshake in REQ
        imem_req_ready = 1'b1;
        branch_control = 1'b1; branch_type = 4'b0100; br_target = 32'h0000_2000;
        step();
        imem_req_ready = 1'b0; branch_control = 1'b0; branch_type = 4'd0;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL req_redir_drop got=%0h exp=0", imem_req_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0BAD;
        step();
        imem_rsp_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL req_redir_req_valid got=%0h exp=1", imem_req_valid); end
        checks++; if (imem_addr !== 32'h0000_2000) begin errors++; $display("FAIL req_redir_addr got=%08h exp=00002000", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL req_redir_if_valid got=%0h exp=0", if_valid); end
        $display("back_to_back: addr=%08h", imem_addr);
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_jalr_misalign();
        test_auipc_only();
        test_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_pc_ctrl.md
IF_PC_CTRL -- requirements
Module: if_pc_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 branch_control  input  1  redirect request from branch resolution, valid in the cycle presented.
REQ-005 branch_type  input  4  {auipc, jal, jalr, btype} one-hot qualifier for branch_control.
REQ-006 br_target  input  32  resolved target address.
REQ-007 stall  input  1  decode not accepting; holds the presented instruction.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  memory accepts request; handshake = valid & ready.
REQ-010 imem_addr  output  32  fetch address, equals pc.
REQ-011 imem_rsp_valid  input  1  instruction return strobe, one per accepted request, at least 1 cycle after the handshake.
REQ-012 imem_rsp_data  input  32  returned instruction.
REQ-013 if_valid  output  1  instruction presented to decode.
REQ-014 if_pc  output  32  pc of the presented instruction.
REQ-015 if_inst  output  32  presented instruction.
REQ-016 flush  output  1  kill younger pipeline stages; combinational, asserted in the redirect cycle.
REQ-017 misalign_exc  output  1  one-cycle registered pulse for a misaligned redirect target.

Function
REQ-018 Redirect taken = branch_control & (branch_type[2:0] != 0); branch_type[3] alone never redirects or flushes.
REQ-019 Effective target = br_target with bit0 cleared when branch_type[1] (jalr); otherwise br_target unchanged.
REQ-020 Effective target[1:0] != 0: no pc update, no flush, misalign_exc high the next cycle for exactly one cycle, FSM unaffected.
REQ-021 Aligned redirect: flush=1 in the same cycle, pc <= target at the clock edge, presented instruction discarded (if_valid 0 next cycle).
REQ-022 At most one outstanding fetch; FSM states REQ, WAIT, HOLD, DROP.
REQ-023 REQ: imem_req_valid=1, imem_addr=pc; handshake -> WAIT.
REQ-024 WAIT: imem_req_valid=0; imem_rsp_valid -> capture if_inst=imem_rsp_data, if_pc=pc, -> HOLD.
REQ-025 HOLD: if_valid=1; stall=0 -> pc <= pc+4 (mod 2^32 wrap), -> REQ; stall=1 -> hold all outputs stable.
REQ-026 DROP: imem_req_valid=0; imem_rsp_valid -> discard data, -> REQ.
REQ-027 Redirect in REQ: with handshake in the same cycle -> DROP; else stay REQ at new pc.
REQ-028 Redirect in WAIT: with imem_rsp_valid in the same cycle -> discard, -> REQ; else -> DROP.
REQ-029 Redirect in HOLD (stall irrelevant) -> REQ at new pc; redirect in DROP -> pc updated, stay DROP.
REQ-030 Redirect overrides stall and the pc+4 update in the same cycle.
REQ-031 if_valid is 1 only in HOLD; one fetch = minimum 3 cycles.

Reset
REQ-032 rst_n low asynchronously forces: state REQ, pc=RESET_PC, if_valid=0, if_pc=0, if_inst=0, misalign_exc=0; imem_req_valid=0 while rst_n low.
REQ-033 First cycle after rst_n rises: imem_req_valid=1, imem_addr=RESET_PC.
REQ-034 Reset mid-transaction: any later imem_rsp_valid for the pre-reset request is treated as the response to the next request (memory side is reset together).

Verification
REQ-035 Reset release, ready=1, rsp 1 cycle later with 32'h0000_0013, stall=0 -> if_pc=8000_0000 valid 1 cycle, next imem_addr=8000_0004.
REQ-036 HOLD with stall=1 for 4 cycles -> if_valid, if_pc, if_inst stable 5 cycles; then pc+4 request.
REQ-037 Redirect jal target 8000_0100 in WAIT, rsp arrives 2 cycles later -> flush 1 cycle, response dropped, next request address 8000_0100, no if_valid for dropped data.
REQ-038 jalr with br_target 8000_0201 -> fetch at 8000_0200; br_target 8000_0202 -> misalign_exc pulse, pc unchanged, flush 0.
REQ-039 branch_control=1, branch_type=4'b1000 -> no flush, no pc change.
REQ-040 pc=FFFF_FFFC sequential -> next imem_addr=0000_0000.
